spi_shift_out_buf: RTL and testbench



---
 rtl/spi_shift_out_buf.sv | 209 ++++++++++++++++++++
 tb/tb_spi_shift_out_buf.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_out_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_shift_out_buf
//  Purpose  : Parametrised SPI transmit serialiser. It has a one-word holding
//             buffer with a valid/ready handshake, so back-to-back words go out
//             with no gap. It has configurable bit order and idle level, and a
//             sticky underrun flag. Bits advance on an external one-cycle
//             strobe.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SDEPTH     word width in bits (2..32)
//    MSB_FIRST  1 = MSB shifted first, 0 = LSB shifted first
//    IDLE_BIT   level driven on SDO while no word is being shifted
//    CWIDTH     bit-counter width, 2**CWIDTH must exceed SDEPTH
//  Ports
//    SPI_Clk           single clock, all state updates on the rising edge
//    SPI_Reset         synchronous, active-high reset
//    SPI_Shift_En      one-cycle strobe: advance one bit
//    SPI_Data_In       parallel word from the source
//    SPI_Data_Valid    SPI_Data_In holds a valid word
//    SPI_Data_Ready    holding buffer can accept a word this cycle
//    SPI_Sdo           registered serial data out
//    SPI_Busy          a word is in the shift register
//    SPI_AlmostEmpty   last bit of the current word is on SDO
//    SPI_Empty         shift register and holding buffer are both empty
//    SPI_Underrun      sticky: a strobe arrived with no data to send
//    SPI_Underrun_Clr  clears SPI_Underrun (a new underrun takes priority)
// ============================================================================
module spi_shift_out_buf #(
  parameter int SDEPTH    = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_BIT  = 1,
  parameter int CWIDTH    = 4
) (
  input  logic              SPI_Clk,
  input  logic              SPI_Reset,
  input  logic              SPI_Shift_En,
  input  logic [SDEPTH-1:0] SPI_Data_In,
  input  logic              SPI_Data_Valid,
  output logic              SPI_Data_Ready,
  output logic              SPI_Sdo,
  output logic              SPI_Busy,
  output logic              SPI_AlmostEmpty,
  output logic              SPI_Empty,
  output logic              SPI_Underrun,
  input  logic              SPI_Underrun_Clr
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic              c_IDLE_LVL  = (IDLE_BIT != 0);
  localparam logic [CWIDTH-1:0] c_CNT_LOAD  = CWIDTH'(SDEPTH);
  localparam logic [CWIDTH-1:0] c_CNT_ONE   = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] c_CNT_ZERO  = '0;
  localparam logic [SDEPTH-1:0] c_IDLE_WORD = {SDEPTH{c_IDLE_LVL}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [CWIDTH-1:0]   r_bitCnt;     // bits of the current word still to present
  logic [SDEPTH-1:0]   r_shiftReg;   // output-end bit mirrors r_sdo
  logic [SDEPTH-1:0]   r_holdReg;
  logic                r_holdFull;
  logic                r_sdo;
  logic                r_underrun;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                w_lastBit;
  logic                w_holdXfer;
  logic                w_accept;
  logic                w_underrunSet;
  logic [SDEPTH-1:0]   w_shiftNext;
  logic                w_nextOutBit;
  logic                w_loadOutBit;

  // The last bit of a word is on SDO when the counter reaches one.
  assign w_lastBit = (r_state == ST_SHIFT) && (r_bitCnt == c_CNT_ONE);

  // The buffered word moves into the shift register when the shifter is idle.
  // It also moves on the strobe that retires the last bit, so the next word
  // follows with no idle bit in between. In IDLE the load consumes any strobe
  // that arrives in the same cycle.
  assign w_holdXfer = r_holdFull & ((r_state == ST_IDLE) | (w_lastBit & SPI_Shift_En));

  // The buffer can take a new word in the same cycle it hands its word on.
  // SPI_Shift_En -> SPI_Data_Ready is the only combinational input-to-output
  // path.
  assign SPI_Data_Ready = ~r_holdFull | w_holdXfer;
  assign w_accept       = SPI_Data_Valid & SPI_Data_Ready;

  // A strobe with nothing to send: the shifter is idle and the buffer is empty.
  assign w_underrunSet  = SPI_Shift_En & (r_state == ST_IDLE) & ~r_holdFull;

  // Bit-order specific wiring. The shifter always moves toward the output end
  // and back-fills with the idle level.
  generate
    if (MSB_FIRST != 0) begin : g_msbFirst
      assign w_shiftNext  = {r_shiftReg[SDEPTH-2:0], c_IDLE_LVL};
      assign w_nextOutBit = r_shiftReg[SDEPTH-2];
      assign w_loadOutBit = r_holdReg[SDEPTH-1];
    end else begin : g_lsbFirst
      assign w_shiftNext  = {c_IDLE_LVL, r_shiftReg[SDEPTH-1:1]};
      assign w_nextOutBit = r_shiftReg[1];
      assign w_loadOutBit = r_holdReg[0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Shifter FSM: state, counter, shift register and registered SDO
  // --------------------------------------------------------------------------
  always_ff @(posedge SPI_Clk) begin
    if (SPI_Reset) begin
      r_state    <= ST_IDLE;
      r_bitCnt   <= c_CNT_ZERO;
      r_shiftReg <= c_IDLE_WORD;
      r_sdo      <= c_IDLE_LVL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_holdXfer) begin
            r_state    <= ST_SHIFT;
            r_bitCnt   <= c_CNT_LOAD;
            r_shiftReg <= r_holdReg;
            r_sdo      <= w_loadOutBit;
          end
        end

        ST_SHIFT: begin
          if (SPI_Shift_En) begin
            if (r_bitCnt != c_CNT_ONE) begin
              r_shiftReg <= w_shiftNext;
              r_sdo      <= w_nextOutBit;
              r_bitCnt   <= r_bitCnt - c_CNT_ONE;
            end else if (r_holdFull) begin
              // Seamless reload: the first bit of the next word follows the
              // last bit of this word directly.
              r_bitCnt   <= c_CNT_LOAD;
              r_shiftReg <= r_holdReg;
              r_sdo      <= w_loadOutBit;
            end else begin
              r_state    <= ST_IDLE;
              r_bitCnt   <= c_CNT_ZERO;
              r_shiftReg <= c_IDLE_WORD;
              r_sdo      <= c_IDLE_LVL;
            end
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_bitCnt   <= c_CNT_ZERO;
          r_shiftReg <= c_IDLE_WORD;
          r_sdo      <= c_IDLE_LVL;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Holding buffer. When a word is accepted and the old word is transferred in
  // the same cycle, the buffer stays full and holds the new word.
  // --------------------------------------------------------------------------
  always_ff @(posedge SPI_Clk) begin
    if (SPI_Reset) begin
      r_holdFull <= 1'b0;
      r_holdReg  <= '0;
    end else if (w_accept) begin
      r_holdFull <= 1'b1;
      r_holdReg  <= SPI_Data_In;
    end else if (w_holdXfer) begin
      r_holdFull <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky underrun flag. A new underrun beats a clear in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge SPI_Clk) begin
    if (SPI_Reset) begin
      r_underrun <= 1'b0;
    end else if (w_underrunSet) begin
      r_underrun <= 1'b1;
    end else if (SPI_Underrun_Clr) begin
      r_underrun <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Status outputs: plain decodes of registered state
  // --------------------------------------------------------------------------
  assign SPI_Sdo         = r_sdo;
  assign SPI_Busy        = (r_state == ST_SHIFT);
  assign SPI_AlmostEmpty = w_lastBit;
  assign SPI_Empty       = (r_state == ST_IDLE) & ~r_holdFull;
  assign SPI_Underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_out_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_shift_out_buf
//  Purpose  : Self-checking bench for spi_shift_out_buf. It builds two
//             configurations (8-bit MSB-first idle-high, and 12-bit LSB-first
//             idle-low). Each configuration gets directed sequences followed
//             by randomized traffic. Every accepted word is expanded into its
//             bit stream and queued. A monitor pops one bit each time the DUT
//             presents a bit on a strobe. A word-level occupancy model predicts
//             the handshake and status flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_shift_out_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit done [2];

  function automatic void check(input string nm, input int cfg,
                                input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cfg=%0d actual=%0h required=%0h time=%0t", nm, cfg, act, exp, $time);
    end
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_cfg
    localparam int D  = (k == 0) ? 8 : 12;
    localparam int MF = (k == 0) ? 1 : 0;
    localparam int IB = (k == 0) ? 1 : 0;

    logic         rst, en, vld, clr;
    logic [D-1:0] din;
    logic         rdy, sdo, busy, ae, emp, unr;

    spi_shift_out_buf #(
      .SDEPTH    (D),
      .MSB_FIRST (MF),
      .IDLE_BIT  (IB),
      .CWIDTH    (4)
    ) u_dut (
      .SPI_Clk          (clk),
      .SPI_Reset        (rst),
      .SPI_Shift_En     (en),
      .SPI_Data_In      (din),
      .SPI_Data_Valid   (vld),
      .SPI_Data_Ready   (rdy),
      .SPI_Sdo          (sdo),
      .SPI_Busy         (busy),
      .SPI_AlmostEmpty  (ae),
      .SPI_Empty        (emp),
      .SPI_Underrun     (unr),
      .SPI_Underrun_Clr (clr)
    );

    // Scoreboard: bits still owed on SDO, in transmission order.
    bit expQ[$];
    // Occupancy model: bits left in the word being sent (0 = idle),
    // whether the buffer holds a word, and the sticky underrun flag.
    int mLeft;
    bit mHold;
    bit mUnr;
    bit armed = 1'b0;

    // One clock cycle: drive inputs after the falling edge, check the flags,
    // then advance the model across the rising edge.
    task automatic step(input bit r, input bit e, input bit v, input bit c,
                        input logic [31:0] d, output bit acc);
      bit xfer;
      bit mRdy;
      @(negedge clk);
      rst = r; en = e; vld = v; clr = c; din = d[D-1:0];
      #1;
      xfer = mHold && (mLeft == 0 || (mLeft == 1 && e));
      mRdy = !mHold || xfer;
      check("ready",        k, rdy,  mRdy);
      check("busy",         k, busy, mLeft > 0);
      check("almost_empty", k, ae,   mLeft == 1);
      check("empty",        k, emp,  (mLeft == 0) && !mHold);
      check("underrun",     k, unr,  mUnr);
      acc = !r && v && mRdy;
      if (acc)
        for (int i = 0; i < D; i++)
          expQ.push_back((MF != 0) ? d[D-1-i] : d[i]);
      @(posedge clk);
      if (r) begin
        mLeft = 0; mHold = 1'b0; mUnr = 1'b0;
        expQ.delete();
      end else begin
        if (e && mLeft == 0 && !mHold) mUnr = 1'b1;
        else if (c)                    mUnr = 1'b0;
        if (xfer)                 mLeft = D;
        else if (e && mLeft > 0)  mLeft = mLeft - 1;
        if (acc)       mHold = 1'b1;
        else if (xfer) mHold = 1'b0;
      end
    endtask

    // Monitor: a presented bit is consumed on each strobe while busy.
    initial begin
      bit b;
      forever begin
        @(negedge clk);
        #2;
        if (armed) begin
          if (busy === 1'b1 && en === 1'b1) begin
            if (expQ.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sdo_extra cfg=%0d actual=unexpected_bit(%0b) required=no_bit time=%0t",
                       k, sdo, $time);
            end else begin
              b = expQ.pop_front();
              check("sdo_bit", k, sdo, b);
            end
          end else if (busy !== 1'b1) begin
            check("sdo_idle", k, sdo, IB);
          end
        end
      end
    end

    // Stimulus
    initial begin
      bit          a;
      bit          have;
      bit          r, e, c;
      logic [31:0] w, pw;
      rst = 1'b1; en = 1'b0; vld = 1'b0; clr = 1'b0; din = '0;
      repeat (2) @(posedge clk);
      mLeft = 0; mHold = 1'b0; mUnr = 1'b0;
      armed = 1'b1;

      // Single word, a pause with no strobes, then the whole word.
      w = (k == 0) ? 32'hA5 : 32'h801;
      step(0, 0, 1, 0, w, a);
      repeat (3) step(0, 0, 0, 0, 0, a);
      repeat (D) step(0, 1, 0, 0, 0, a);
      repeat (2) step(0, 0, 0, 0, 0, a);

      // Underrun: strobe while empty, flag sticks through a word, clear,
      // then clear together with a new underrun.
      step(0, 1, 0, 0, 0, a);
      step(0, 0, 0, 0, 0, a);
      step(0, 0, 1, 0, 32'h5A3, a);
      repeat (D + 1) step(0, 1, 0, 0, 0, a);
      step(0, 0, 0, 1, 0, a);
      step(0, 0, 0, 0, 0, a);
      step(0, 1, 0, 1, 0, a);
      step(0, 0, 0, 0, 0, a);
      step(0, 0, 0, 1, 0, a);

      // Back-to-back words with continuous strobes.
      step(0, 1, 1, 0, (k == 0) ? 32'h3C : 32'hC3A, a);
      step(0, 1, 1, 0, (k == 0) ? 32'hFF : 32'hFFF, a);
      repeat (2 * D + 2) step(0, 1, 0, 0, 0, a);
      step(0, 0, 0, 1, 0, a);

      // Reset after three bits, with a second word held in the buffer.
      step(0, 0, 1, 0, 32'hA5, a);
      step(0, 0, 1, 0, 32'h0F, a);
      repeat (3) step(0, 1, 0, 0, 0, a);
      step(1, 0, 0, 0, 0, a);
      repeat (4) step(0, 1, 0, 0, 0, a);
      step(0, 0, 0, 1, 0, a);

      // Randomized traffic.
      have = 1'b0;
      pw   = '0;
      for (int n = 0; n < 3000; n++) begin
        if (!have && $urandom_range(0, 2) != 0) begin
          have = 1'b1;
          pw   = $urandom;
        end
        r = ($urandom_range(0, 299) == 0);
        e = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 19) == 0);
        step(r, e, have, c, pw, a);
        if (a) have = 1'b0;
      end

      // Drain everything still owed, then confirm nothing is left over.
      repeat (3 * D) step(0, 1, 0, 0, 0, a);
      step(0, 0, 0, 0, 0, a);
      check("drain_left", k, expQ.size(), 0);
      done[k] = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1]) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(done[0] && done[1])) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=not_done required=done cycles=%0d", cyc);
    end
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
